// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
// The UNLOAD state is only reachable when FFT_SEQ_BITREV_UNLOAD_EN is defined.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    UNLOAD,
    DONE
  } fft_seq_state_t;

  // Reverses the low 'width' bits of value; supports widths up to 10 (N = 1024).
  function automatic logic [9:0] bitrev(input logic [9:0] value, input int width);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Bus between the FFT stage sequencer, the frame controller, the sample RAM and the butterfly.
// out_valid/out_index exist only when FFT_SEQ_BITREV_UNLOAD_EN is defined.
interface fft_stage_sequencer_if #(parameter int LOG2N = 4);
  logic             start;
  logic             busy;
  logic             done;
  logic [3:0]       stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic             bf_en;
  logic [LOG2N-2:0] bf_twiddle_idx;
  logic             bf_en_out;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             seq_err;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  logic             out_valid;
  logic [LOG2N-1:0] out_index;
`endif

  modport master (
    input  start, bf_en_out,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, bf_en, bf_twiddle_idx,
           wr_en, wr_addr_a, wr_addr_b, seq_err
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    , output out_valid, out_index
`endif
  );

  modport slave (
    output start, bf_en_out,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, bf_en, bf_twiddle_idx,
           wr_en, wr_addr_a, wr_addr_b, seq_err
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    , input out_valid, out_index
`endif
  );
endinterface

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear; DEPTH = 0 is a wire.
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_data = i_data;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

      always_ff @(posedge clk) begin
        // NOTE: the whole pipe is cleared so in-flight entries die with the reset instead of surfacing later.
        if (!i_clr_n) begin
          r_pipe <= '0;
        end else begin
          // NOTE: non-blocking updates make each tap take its neighbour's pre-edge value, giving a true shift.
          r_pipe[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_data = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_stage_sequencer.sv
// Drives one radix-2 DIF butterfly through all LOG2N stages of an in-place FFT.
// Define FFT_SEQ_BITREV_UNLOAD_EN to add a natural-order unload pass before done.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N          = 4,
  parameter int BF_LATENCY     = 4,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_stage_sequencer_if.master bus
);

  localparam int N    = 1 << LOG2N;
  localparam int H    = N / 2;
  localparam int L    = MEM_RD_LATENCY + BF_LATENCY;
  localparam int CW   = clog2(L) + 1;
  localparam int TW_W = LOG2N - 1;
  localparam logic [LOG2N-1:0] ONE = LOG2N'(1);
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  localparam int D1_W = 1 + LOG2N + 1 + TW_W;
`else
  localparam int D1_W = 1 + TW_W;
`endif
  localparam int D2_W = 1 + 2 * LOG2N;

  fft_seq_state_t   r_state, w_next;
  logic [LOG2N:0]   r_idx;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_stage;
  logic             r_seq_err;

  logic             w_issue_last, w_drain_last, w_last_stage;
  logic             w_issue, w_rd_en;
  logic [LOG2N-1:0] w_j, w_span, w_mask, w_k, w_addr_a, w_addr_b;
  logic [LOG2N-1:0] w_rd_addr_a, w_rd_addr_b;
  logic [TW_W-1:0]  w_twiddle;
  logic [D1_W-1:0]  w_d1_in, w_d1_out;
  logic [D2_W-1:0]  w_d2_in, w_d2_out;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  logic             w_unl_valid, w_unload_last;
  assign w_unload_last = (r_idx == (LOG2N+1)'(N - 1 + MEM_RD_LATENCY));
`endif

  assign w_issue_last = (r_idx == (LOG2N+1)'(H - 1));
  assign w_drain_last = (r_cnt == CW'(L - 1));
  assign w_last_stage = (r_stage == 4'(LOG2N - 1));

  // Butterfly j of stage s pairs a and a+span inside group j/span.
  always_comb begin
    w_j       = r_idx[LOG2N-1:0];
    w_span    = LOG2N'(H >> r_stage);
    w_mask    = w_span - ONE;
    w_k       = w_j & w_mask;
    w_addr_a  = ((w_j & ~w_mask) << 1) | w_k;
    w_addr_b  = w_addr_a | w_span;
    w_twiddle = TW_W'(w_k << r_stage);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    w_next      = r_state;
    w_issue     = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr_a = '0;
    w_rd_addr_b = '0;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    w_unl_valid = 1'b0;
`endif
    case (r_state)
      IDLE:  if (bus.start) w_next = ISSUE;
      ISSUE: begin
        w_issue     = 1'b1;
        w_rd_en     = 1'b1;
        w_rd_addr_a = w_addr_a;
        w_rd_addr_b = w_addr_b;
        if (w_issue_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_drain_last) begin
          if (!w_last_stage) w_next = ISSUE;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
          else               w_next = UNLOAD;
`else
          else               w_next = DONE;
`endif
        end
      end
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
      UNLOAD: begin
        w_unl_valid = (r_idx < (LOG2N+1)'(N));
        w_rd_en     = w_unl_valid;
        if (w_unl_valid) w_rd_addr_a = LOG2N'(bitrev(10'(r_idx[LOG2N-1:0]), LOG2N));
        if (w_unload_last) w_next = DONE;
      end
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_stage   <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_seq_err <= r_seq_err | (bus.bf_en_out != w_d2_out[D2_W-1]);
      case (r_state)
        ISSUE: r_idx <= w_issue_last ? '0 : r_idx + 1'b1;
        DRAIN: begin
          r_cnt <= w_drain_last ? '0 : r_cnt + 1'b1;
          if (w_drain_last && !w_last_stage) r_stage <= r_stage + 1'b1;
        end
        UNLOAD: r_idx <= r_idx + 1'b1;
        DONE:   r_stage <= '0;
        default: begin
          r_idx <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  assign w_d1_in = {w_unl_valid, w_unl_valid ? r_idx[LOG2N-1:0] : '0,
                    w_issue, w_issue ? w_twiddle : '0};
  assign bus.out_valid = w_d1_out[D1_W-1];
  assign bus.out_index = w_d1_out[D1_W-2 -: LOG2N];
`else
  assign w_d1_in = {w_issue, w_issue ? w_twiddle : '0};
`endif
  assign w_d2_in = {w_issue, w_rd_addr_a, w_rd_addr_b};

  fft_delay_line #(.WIDTH(D1_W), .DEPTH(MEM_RD_LATENCY)) u_bf_delay (
    .clk(clk), .i_clr_n(rst_n), .i_data(w_d1_in), .o_data(w_d1_out)
  );

  fft_delay_line #(.WIDTH(D2_W), .DEPTH(L)) u_wr_delay (
    .clk(clk), .i_clr_n(rst_n), .i_data(w_d2_in), .o_data(w_d2_out)
  );

  assign bus.busy           = (r_state == ISSUE) || (r_state == DRAIN) || (r_state == UNLOAD);
  assign bus.done           = (r_state == DONE);
  assign bus.stage          = r_stage;
  assign bus.rd_en          = w_rd_en;
  assign bus.rd_addr_a      = w_rd_addr_a;
  assign bus.rd_addr_b      = w_rd_addr_b;
  assign bus.bf_en          = w_d1_out[TW_W];
  assign bus.bf_twiddle_idx = w_d1_out[TW_W-1:0];
  assign bus.wr_en          = w_d2_out[D2_W-1];
  assign bus.wr_addr_a      = w_d2_out[2*LOG2N-1:LOG2N];
  assign bus.wr_addr_b      = w_d2_out[LOG2N-1:0];
  assign bus.seq_err        = r_seq_err;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (LOG2N=4, BF_LATENCY=4, MEM_RD_LATENCY=1).
// Cycle c is the interval after clock edge c-1; edge 0 samples start.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int LOG2N = 4, BF_LATENCY = 4, MEM_RD_LATENCY = 1;
  localparam int N = 16, H = 8, L = 5, STAGE_CYC = H + L;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  localparam int DONE_CYC = 70, RD_TOTAL = 48;
`else
  localparam int DONE_CYC = 53, RD_TOTAL = 32;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic late = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.LOG2N(LOG2N)) bus ();

  fft_stage_sequencer #(
    .LOG2N(LOG2N), .BF_LATENCY(BF_LATENCY), .MEM_RD_LATENCY(MEM_RD_LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Butterfly model: echoes bf_en after BF_LATENCY cycles, or one cycle later when 'late'.
  logic [BF_LATENCY:0] bf_sr = '0;
  always @(posedge clk) begin
    if (!rst_n) bf_sr <= '0;
    else        bf_sr <= {bf_sr[BF_LATENCY-1:0], bus.bf_en};
  end
  assign bus.bf_en_out = late ? bf_sr[BF_LATENCY] : bf_sr[BF_LATENCY-1];

  logic [31:0] all_outs;
  assign all_outs = {3'b0, bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr_a,
                     bus.rd_addr_b, bus.bf_en, bus.bf_twiddle_idx, bus.wr_en,
                     bus.wr_addr_a, bus.wr_addr_b, bus.seq_err};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  bit busy_log [0:127];
  bit done_log [0:127];
  int rd_a[$], rd_b[$], rd_c[$], tw_v[$], bf_c[$], wr_a[$], wr_b[$], wr_c[$];
  int ov_c[$], ov_i[$];

  task automatic clear_logs();
    for (int c = 0; c < 128; c++) begin
      busy_log[c] = 1'b0;
      done_log[c] = 1'b0;
    end
    rd_a.delete(); rd_b.delete(); rd_c.delete(); tw_v.delete(); bf_c.delete();
    wr_a.delete(); wr_b.delete(); wr_c.delete(); ov_c.delete(); ov_i.delete();
  endtask

  task automatic capture(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      busy_log[c] = bus.busy;
      done_log[c] = bus.done;
      if (bus.rd_en) begin
        rd_a.push_back(int'(bus.rd_addr_a)); rd_b.push_back(int'(bus.rd_addr_b)); rd_c.push_back(c);
      end
      if (bus.bf_en) begin
        tw_v.push_back(int'(bus.bf_twiddle_idx)); bf_c.push_back(c);
      end
      if (bus.wr_en) begin
        wr_a.push_back(int'(bus.wr_addr_a)); wr_b.push_back(int'(bus.wr_addr_b)); wr_c.push_back(c);
      end
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
      if (bus.out_valid) begin
        ov_c.push_back(c); ov_i.push_back(int'(bus.out_index));
      end
`endif
    end
  endtask

  task automatic launch(input bit hold);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Hand-computed spot vectors: issue index, addr_a, addr_b, twiddle.
  int spot [5][4] = '{'{0, 0, 8, 0}, '{7, 7, 15, 7}, '{11, 3, 7, 6},
                      '{12, 8, 12, 0}, '{31, 14, 15, 0}};
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
  int rev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`endif

  task automatic check_frame(input string tag);
    int n_done, done_at, idx, span, ea, eb, rc;
    n_done = 0;
    done_at = -1;
    for (int c = 1; c <= DONE_CYC + 5; c++) begin
      if (done_log[c]) begin
        n_done++;
        done_at = c;
      end
    end
    check({tag, "_busy_rise"}, {31'b0, busy_log[1]}, 1);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_done_cycle"}, done_at, DONE_CYC);
    check({tag, "_busy_before_done"}, {31'b0, busy_log[DONE_CYC-1]}, 1);
    check({tag, "_busy_at_done"}, {31'b0, busy_log[DONE_CYC]}, 0);
    check({tag, "_n_rd"}, rd_a.size(), RD_TOTAL);
    check({tag, "_n_bf"}, tw_v.size(), 32);
    check({tag, "_n_wr"}, wr_a.size(), 32);
    if (rd_a.size() == RD_TOTAL && tw_v.size() == 32 && wr_a.size() == 32) begin
      for (int i = 0; i < 5; i++) begin
        check({tag, "_spot_rd"}, (rd_a[spot[i][0]] << 8) | rd_b[spot[i][0]],
              (spot[i][1] << 8) | spot[i][2]);
        check({tag, "_spot_tw"}, tw_v[spot[i][0]], spot[i][3]);
      end
      idx = 0;
      for (int s = 0; s < LOG2N; s++) begin
        span = N >> (s + 1);
        for (int g = 0; g < N / (2 * span); g++) begin
          for (int k = 0; k < span; k++) begin
            ea = g * 2 * span + k;
            eb = ea + span;
            rc = 1 + s * STAGE_CYC + (idx % H);
            check({tag, "_rd"}, (rd_c[idx] << 16) | (rd_a[idx] << 8) | rd_b[idx],
                  (rc << 16) | (ea << 8) | eb);
            check({tag, "_tw"}, (bf_c[idx] << 16) | tw_v[idx], ((rc + 1) << 16) | (k << s));
            check({tag, "_wr"}, (wr_c[idx] << 16) | (wr_a[idx] << 8) | wr_b[idx],
                  ((rc + L) << 16) | (ea << 8) | eb);
            idx++;
          end
        end
      end
      for (int s = 0; s < LOG2N - 1; s++)
        check({tag, "_wr_before_next_rd"}, {31'b0, wr_c[8*s+7] < rd_c[8*s+8]}, 1);
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
      check({tag, "_n_out"}, ov_c.size(), N);
      if (ov_c.size() == N) begin
        for (int m = 0; m < N; m++) begin
          check({tag, "_unload_rd"}, (rd_c[32+m] << 16) | (rd_a[32+m] << 8) | rd_b[32+m],
                ((53 + m) << 16) | (rev_tab[m] << 8));
          check({tag, "_out"}, (ov_c[m] << 16) | ov_i[m], ((54 + m) << 16) | m);
        end
      end
`endif
    end
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", all_outs, 0);
    check("reset_state", dut.r_state, IDLE);
    rst_n = 1'b1;

    // Plain frame.
    clear_logs();
    launch(1'b0);
    capture(DONE_CYC + 5);
    check_frame("frameA");
    check("frameA_seq_err", {31'b0, bus.seq_err}, 0);

    // start held high: one frame, next one only after done.
    clear_logs();
    launch(1'b1);
    capture(DONE_CYC + 2);
    begin
      int n_done, n_rd_in_frame;
      n_done = 0;
      n_rd_in_frame = 0;
      for (int c = 1; c <= DONE_CYC + 2; c++) if (done_log[c]) n_done++;
      foreach (rd_c[i]) if (rd_c[i] <= DONE_CYC) n_rd_in_frame++;
      check("held_done_pulses", n_done, 1);
      check("held_done_cycle", {31'b0, done_log[DONE_CYC]}, 1);
      check("held_rd_in_frame", n_rd_in_frame, RD_TOTAL);
      check("held_idle_gap", {31'b0, busy_log[DONE_CYC+1]}, 0);
      check("held_restart", {31'b0, busy_log[DONE_CYC+2]}, 1);
    end
    bus.start = 1'b0;
    pulse_reset();

    // Reset during stage-1 drain.
    clear_logs();
    launch(1'b0);
    capture(22);
    check("pre_rst_stage", {28'b0, bus.stage}, 1);
    pulse_reset();
    @(negedge clk);
    check("midrst_outs", all_outs, 0);
    check("midrst_state", dut.r_state, IDLE);
    clear_logs();
    capture(12);
    check("midrst_no_wr", wr_a.size(), 0);
    check("midrst_no_rd", rd_a.size(), 0);
    clear_logs();
    launch(1'b0);
    capture(DONE_CYC + 5);
    check_frame("frameB");

    // Late butterfly result sets the sticky error; wr_en keeps its own timing.
    late = 1'b1;
    clear_logs();
    launch(1'b0);
    capture(DONE_CYC + 5);
    check("late_seq_err", {31'b0, bus.seq_err}, 1);
    check("late_n_wr", wr_a.size(), 32);
    check("late_done_cycle", {31'b0, done_log[DONE_CYC]}, 1);
    late = 1'b0;
    repeat (5) @(negedge clk);
    check("seq_err_sticky", {31'b0, bus.seq_err}, 1);
    pulse_reset();
    @(negedge clk);
    check("seq_err_cleared", {31'b0, bus.seq_err}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
